// File: rtl/pri_sel_nbit.sv
// pri_sel_nbit: keeps only the highest-priority request codes by bitwise elimination
// (MSB first, one bit per cycle) and picks a round-robin winner among the survivors.
module pri_sel_nbit #(
  parameter int N = 16,
  parameter int P = 4,
  parameter int RR_EN = 1,
  localparam int C = $clog2(P)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [C-1:0] in_i [N],
  input  logic         update_i,
  input  logic         accept_i,
  output logic         busy_o,
  output logic [C-1:0] out_o [N],
  output logic [N-1:0] req_out_o,
  output logic [N-1:0] gnt_o,
  output logic         ready_o
);
  localparam int KW = C > 1 ? $clog2(C) : 1;
  localparam int PW = $clog2(N);
  localparam logic [C-1:0] TOP = C'(1) << (C - 1);

  typedef enum logic {IDLE, ELIM} state_t;

  state_t         state_q;
  logic [KW-1:0]  k_q;
  logic [PW-1:0]  ptr_q, win;
  logic [C-1:0]   data_q [N];
  logic [C-1:0]   elim_d [N];
  logic [C-1:0]   out_q [N];
  logic [N-1:0]   req_d, gnt_d, req_q, gnt_q;
  logic [C-1:0]   msk;
  logic           ready_q, any, last, found;

  assign last = k_q == KW'(C - 1);

  // A code survives if it has the current bit set, unless nobody does.
  always_comb begin
    msk = TOP >> k_q;
    any = 1'b0;
    for (int i = 0; i < N; i++) any = any | (|(data_q[i] & msk));
    for (int i = 0; i < N; i++) begin
      elim_d[i] = (any && !(|(data_q[i] & msk))) ? '0 : data_q[i];
      req_d[i] = |elim_d[i];
    end
  end

  always_comb begin
    gnt_d = '0;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!found && req_d[(int'(ptr_q) + o) % N]) begin
        gnt_d[(int'(ptr_q) + o) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) if (gnt_q[i]) win = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      ptr_q   <= '0;
      data_q  <= '{default: '0};
      out_q   <= '{default: '0};
      req_q   <= '0;
      gnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (state_q == IDLE) begin
        if (update_i) begin
          data_q  <= in_i;
          k_q     <= '0;
          state_q <= ELIM;
        end
      end else begin
        data_q <= elim_d;
        k_q    <= last ? '0 : k_q + 1'b1;
        if (last) begin
          state_q <= IDLE;
          out_q   <= elim_d;
          req_q   <= req_d;
          gnt_q   <= gnt_d;
          ready_q <= 1'b1;
        end
      end
      if (RR_EN != 0 && ready_q && accept_i && |gnt_q)
        ptr_q <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  assign busy_o    = state_q == ELIM;
  assign out_o     = out_q;
  assign req_out_o = req_q;
  assign gnt_o     = gnt_q;
  assign ready_o   = ready_q;
endmodule

// File: tb/tb_pri_sel_nbit.sv
// tb_pri_sel_nbit: directed vectors into a scoreboard queue; a negedge monitor
// pops and compares whenever a DUT raises ready.
module tb_pri_sel_nbit;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a_in [4];
  logic [1:0] a_out [4];
  logic       a_upd = 1'b0, a_acc = 1'b0, a_busy, a_rdy;
  logic [3:0] a_req, a_gnt;
  logic [2:0] b_in [4];
  logic [2:0] b_out [4];
  logic       b_upd = 1'b0, b_acc = 1'b0, b_busy, b_rdy;
  logic [3:0] b_req, b_gnt;

  pri_sel_nbit #(.N(4), .P(4), .RR_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_i(a_in), .update_i(a_upd), .accept_i(a_acc),
    .busy_o(a_busy), .out_o(a_out), .req_out_o(a_req), .gnt_o(a_gnt), .ready_o(a_rdy));

  pri_sel_nbit #(.N(4), .P(8), .RR_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_i(b_in), .update_i(b_upd), .accept_i(b_acc),
    .busy_o(b_busy), .out_o(b_out), .req_out_o(b_req), .gnt_o(b_gnt), .ready_o(b_rdy));

  typedef struct {logic [11:0] o; logic [3:0] r; logic [3:0] g; int c;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int cyc = 0, checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask

  function automatic logic [11:0] pk(input logic [11:0] x0, x1, x2, x3);
    return x0 | (x1 << 3) | (x2 << 6) | (x3 << 9);
  endfunction

  always @(negedge clk) begin
    if (reset && a_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_ready", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_ready_cycle", cyc, ea.c);
        chk("a_out", pk(a_out[0], a_out[1], a_out[2], a_out[3]), ea.o);
        chk("a_req_out", a_req, ea.r);
        chk("a_gnt", a_gnt, ea.g);
      end
    end
    if (reset && b_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_ready", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_ready_cycle", cyc, eb.c);
        chk("b_out", pk(b_out[0], b_out[1], b_out[2], b_out[3]), eb.o);
        chk("b_req_out", b_req, eb.r);
        chk("b_gnt", b_gnt, eb.g);
      end
    end
  end

  // Called at a negedge; leaves at the negedge after the sampling edge.
  task automatic issue_a(input int v[4], input bit push, input logic [11:0] o,
                         input logic [3:0] r, input logic [3:0] g);
    for (int i = 0; i < 4; i++) a_in[i] = 2'(v[i]);
    a_upd = 1'b1;
    if (push) qa.push_back('{o, r, g, cyc + 3});
    @(negedge clk);
    a_upd = 1'b0;
    chk("a_busy_after_update", a_busy, 1);
  endtask

  task automatic issue_b(input int v[4], input logic [11:0] o,
                         input logic [3:0] r, input logic [3:0] g);
    for (int i = 0; i < 4; i++) b_in[i] = 3'(v[i]);
    b_upd = 1'b1;
    qb.push_back('{o, r, g, cyc + 4});
    @(negedge clk);
    b_upd = 1'b0;
    chk("b_busy_after_update", b_busy, 1);
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    chk("a_drain_timeout", qa.size(), 0);
    chk("b_drain_timeout", qb.size(), 0);
    chk("a_busy_idle", a_busy, 0);
    chk("b_busy_idle", b_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin a_in[i] = '0; b_in[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_ready", a_rdy, 0);
    chk("rst_req", a_req, 0);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_out", pk(a_out[0], a_out[1], a_out[2], a_out[3]), 0);
    reset = 1'b1;
    a_acc = 1'b1;
    issue_a('{1, 3, 2, 3}, 1, pk(0, 3, 0, 3), 4'b1010, 4'b0010);
    drain();
    issue_a('{1, 3, 2, 3}, 1, pk(0, 3, 0, 3), 4'b1010, 4'b1000);
    drain();
    issue_a('{1, 3, 2, 3}, 1, pk(0, 3, 0, 3), 4'b1010, 4'b0010);
    drain();
    issue_a('{0, 0, 0, 0}, 1, pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    drain();
    a_acc = 1'b0;
    issue_a('{1, 3, 2, 3}, 1, pk(0, 3, 0, 3), 4'b1010, 4'b1000);
    drain();
    issue_a('{1, 0, 1, 0}, 1, pk(1, 0, 1, 0), 4'b0101, 4'b0100);
    drain();
    issue_a('{0, 2, 3, 1}, 1, pk(0, 0, 3, 0), 4'b0100, 4'b0100);
    drain();
    issue_a('{2, 2, 1, 0}, 1, pk(2, 2, 0, 0), 4'b0011, 4'b0001);
    a_in = '{2'd3, 2'd0, 2'd0, 2'd0};
    a_upd = 1'b1;
    @(negedge clk);
    a_upd = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    issue_a('{1, 3, 2, 3}, 0, '0, '0, '0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_rdy, 0);
    chk("abort_req", a_req, 0);
    chk("abort_gnt", a_gnt, 0);
    chk("abort_out", pk(a_out[0], a_out[1], a_out[2], a_out[3]), 0);
    repeat (6) @(negedge clk);
    issue_a('{1, 3, 2, 3}, 1, pk(0, 3, 0, 3), 4'b1010, 4'b0010);
    drain();
    b_acc = 1'b1;
    issue_b('{5, 7, 6, 7}, pk(0, 7, 0, 7), 4'b1010, 4'b0010);
    drain();
    issue_b('{5, 7, 6, 7}, pk(0, 7, 0, 7), 4'b1010, 4'b0010);
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pri_sel_nbit.md
PRI_SEL_NBIT -- requirements
Module: pri_sel_nbit

Interface
REQ-001 SHALL have parameter N, default 16: number of request channels, N >= 2.
REQ-002 SHALL have parameter P, default 4: number of priority levels, a power of two, P >= 2.
REQ-003 SHALL have derived parameter C = clog2(P): priority code width and elimination cycle count.
REQ-004 SHALL have parameter RR_EN, default 1: 1 enables round-robin pointer advance; 0 fixes the pointer at 0 (lowest index wins).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-low; clears all state.
REQ-007 in[0:N-1]  input  C each  per-channel priority code; 0 = no request, P-1 = highest.
REQ-008 update  input  1  start request; sampled only in IDLE.
REQ-009 accept  input  1  consumer took the grant; sampled only while ready=1.
REQ-010 busy  output  1  high while elimination is in progress.
REQ-011 out[0:N-1]  output  C each  registered input codes; only the maximum-priority channels are kept, all others are 0.
REQ-012 req_out  output  N  req_out[i] = OR of out[i].
REQ-013 gnt  output  N  one-hot round-robin winner among req_out; all zero if req_out = 0.
REQ-014 ready  output  1  one-cycle pulse marking that new out, req_out and gnt values are valid.

Function
REQ-015 The state machine SHALL have states IDLE and ELIM, plus a bit counter k of width clog2(C), minimum 1 bit.
REQ-016 In IDLE with update=1, the block SHALL capture in into data[], set k=0 and move to ELIM; in IDLE with update=0 it SHALL stay in IDLE.
REQ-017 Each ELIM cycle SHALL compute mid[i] = data[i][C-1-k]:
- if any mid[i]=1, every data[i] with mid[i]=0 SHALL be cleared;
- if all mid[i]=0, data SHALL be unchanged.
REQ-018 ELIM SHALL run for exactly C cycles with k = 0..C-1 (MSB first); after k=C-1 the state SHALL return to IDLE.
REQ-019 On the clock edge that ends k=C-1, the block SHALL register out = the final masked data, req_out and gnt, and set ready=1 for exactly one cycle.
REQ-020 Latency: update sampled in cycle t -> busy=1 in cycles t+1..t+C -> ready=1 in cycle t+C+1.
REQ-021 update asserted while busy=1 SHALL be ignored, with no queuing; update asserted in the ready cycle SHALL be accepted normally.
REQ-022 out, req_out and gnt SHALL hold their values until the next ready pulse.
REQ-023 gnt SHALL select the first index j with req_out[j]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-024 If RR_EN=1, accept=1 and gnt!=0 in the ready cycle, ptr SHALL become (winner+1) mod N; otherwise ptr SHALL be unchanged.
REQ-025 accept outside the ready cycle SHALL have no effect.
REQ-026 All-zero input SHALL still complete in C cycles, giving out=0, req_out=0, gnt=0, a ready pulse, and no change to ptr.
REQ-027 Ties at maximum priority SHALL all survive in out and req_out; only gnt breaks the tie.

Reset
REQ-028 reset=0 at a clock edge SHALL set: state=IDLE, k=0, ptr=0, data=0, out=0, req_out=0, gnt=0, ready=0, busy=0.
REQ-029 reset asserted during ELIM SHALL abort the operation, with no ready pulse and no update to out.
REQ-030 Out of reset, the block SHALL accept update in the first cycle with reset=1.

Verification (N=4, P=4, C=2 unless noted)
REQ-031 in={1,3,2,3}, update at t, ptr=0 -> busy at t+1..t+2; ready at t+3; out={0,3,0,3}; req_out=4'b1010; gnt=4'b0010.
REQ-032 Continuing REQ-031:
- accept=1 in the ready cycle; repeat the same input -> gnt=4'b1000;
- accept again -> ptr wraps to 0; next gnt=4'b0010.
REQ-033 in all zero, update -> ready at t+3; out=0; req_out=0; gnt=0; ptr unchanged.
REQ-034 update at t; new update with in={3,0,0,0} at t+1 -> the second update is ignored; the result matches the first input; a single ready pulse.
REQ-035 reset=0 at t+1 during ELIM -> no ready pulse; all outputs 0; a fresh update completes normally.
REQ-036 P=8, C=3, in={5,7,6,7}, RR_EN=0 -> ready at t+4; out={0,7,0,7}; gnt=4'b0010, repeated after accept.
